can_reg_arbiter: RTL

CAN_REG_ARBITER -- requirements
Module: can_reg_arbiter

---
 rtl/can_reg_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/can_reg_arbiter.sv
// rtl/can_reg_arbiter.sv - round-robin bus/debug arbiter onto a single device register port
// Optional BUSY abort counter enabled by defining CAN_ARB_TIMEOUT_EN.
module can_reg_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_valid,
  input  logic [3:0]        bus_wstrb,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              bus_ready,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              la_req,
  input  logic              la_wr_en,
  input  logic [ADDR_W-1:0] la_addr,
  input  logic [DATA_W-1:0] la_wdata,
  output logic              la_done,
  output logic [DATA_W-1:0] la_rdata,
  output logic              reg_req,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic [3:0]        reg_be,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q;
  logic                pref_la_q;
  logic                gnt_la_q;
  logic                bus_ready_q, la_done_q;
  logic [DATA_W-1:0]   bus_rdata_q, la_rdata_q;
  logic                reg_req_q, reg_wr_en_q;
  logic [ADDR_W-1:0]   reg_addr_q;
  logic [DATA_W-1:0]   reg_wr_data_q;
  logic [3:0]          reg_be_q;

  logic                grant_la_d, wr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [3:0]          be_d;

`ifdef CAN_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_err_q;
`endif

  // pref_la_q marks the debug side as next in line when both contend.
  always_comb begin
    grant_la_d = la_req && (!bus_valid || pref_la_q);
    if (grant_la_d) begin
      wr_d    = la_wr_en;
      addr_d  = la_addr;
      wdata_d = la_wdata;
      be_d    = la_wr_en ? 4'b1111 : 4'b0000;
    end else begin
      wr_d    = |bus_wstrb;
      addr_d  = bus_addr;
      wdata_d = bus_wdata;
      be_d    = bus_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pref_la_q     <= 1'b0;
      gnt_la_q      <= 1'b0;
      bus_ready_q   <= 1'b0;
      la_done_q     <= 1'b0;
      bus_rdata_q   <= '0;
      la_rdata_q    <= '0;
      reg_req_q     <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      reg_be_q      <= 4'b0000;
`ifdef CAN_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      bus_ready_q <= 1'b0;
      la_done_q   <= 1'b0;
`ifdef CAN_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus_valid || la_req) begin
            state_q       <= BUSY;
            gnt_la_q      <= grant_la_d;
            pref_la_q     <= !grant_la_d;
            reg_req_q     <= 1'b1;
            reg_wr_en_q   <= wr_d;
            reg_addr_q    <= addr_d;
            reg_wr_data_q <= wdata_d;
            reg_be_q      <= be_d;
`ifdef CAN_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
          end
        end
        BUSY: begin
          if (reg_ack) begin
            state_q   <= RESP;
            reg_req_q <= 1'b0;
            if (!reg_wr_en_q) begin
              if (gnt_la_q) la_rdata_q  <= reg_rd_data;
              else          bus_rdata_q <= reg_rd_data;
            end
            if (gnt_la_q) la_done_q   <= 1'b1;
            else          bus_ready_q <= 1'b1;
          end
`ifdef CAN_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q       <= RESP;
            reg_req_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            if (!reg_wr_en_q) begin
              if (gnt_la_q) la_rdata_q  <= '1;
              else          bus_rdata_q <= '1;
            end
            if (gnt_la_q) la_done_q   <= 1'b1;
            else          bus_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_ready   = bus_ready_q;
  assign bus_rdata   = bus_rdata_q;
  assign la_done     = la_done_q;
  assign la_rdata    = la_rdata_q;
  assign reg_req     = reg_req_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign reg_be      = reg_be_q;
`ifdef CAN_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
